instr_fetch: RTL

Front-end fetch unit that generates sequential PCs, issues in-order instruction-memory reads and buffers returned instruction words in a small FIFO. It drives the decode stage's instruction/PC inputs with a valid/ready handshake, so decode can stall on reservation-station or ROB backpressure. A redirect port from branch resolution flushes the buffer and in-flight reads and restarts fetch at a new PC.

---
 rtl/instr_fetch.sv | 119 +++++++++++
 1 files changed

// File: rtl/instr_fetch.sv
// instr_fetch: front-end fetch unit.
//   Issues sequential, in-order instruction-memory reads (bounded by
//   MAX_INFLIGHT outstanding reads). It buffers returned words with their
//   PCs in a QUEUE_DEPTH-entry FIFO that feeds decode over a valid/ready
//   handshake. A redirect flushes the queue, discards every outstanding
//   read and restarts fetch at the new PC.
// Ports:
//   clk, rst (async, active-low)
//   OUT_memReq/OUT_memAddr/IN_memBusy   : read request channel
//   IN_memValid/IN_memData              : in-order read responses
//   OUT_valid/OUT_instr/OUT_pc/IN_ready : decode handshake (queue head)
//   IN_redirect/IN_redirectPC           : flush and restart
module instr_fetch #(
  parameter int unsigned QUEUE_DEPTH  = 4,
  parameter int unsigned MAX_INFLIGHT = 2,
  parameter logic [31:0] RESET_PC     = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  output logic        OUT_memReq,
  output logic [31:0] OUT_memAddr,
  input  logic        IN_memBusy,
  input  logic        IN_memValid,
  input  logic [31:0] IN_memData,
  output logic        OUT_valid,
  output logic [31:0] OUT_instr,
  output logic [31:0] OUT_pc,
  input  logic        IN_ready,
  input  logic        IN_redirect,
  input  logic [31:0] IN_redirectPC
);
  localparam int QW = $clog2(QUEUE_DEPTH);
  localparam int CW = QW + 1;
  localparam int IW = $clog2(MAX_INFLIGHT + 1);
  localparam int PW = (MAX_INFLIGHT > 1) ? $clog2(MAX_INFLIGHT) : 1;

  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   q_instr_q [QUEUE_DEPTH];
  logic [31:0]   q_pc_q    [QUEUE_DEPTH];
  logic [QW-1:0] head_q, head_d, tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic [IW-1:0] infl_q, infl_d, drop_q, drop_d;
  logic [31:0]   pf_q [MAX_INFLIGHT];
  logic [PW-1:0] pf_wr_q, pf_wr_d, pf_rd_q, pf_rd_d;
  logic [31:0]   credits;
  logic          accept, deq, enq;

  // PC FIFO depth need not be a power of two, so wrap explicitly.
  function automatic logic [PW-1:0] pf_inc(input logic [PW-1:0] p);
    return (p == PW'(MAX_INFLIGHT - 1)) ? '0 : p + PW'(1);
  endfunction

  // Queue slots already spoken for: buffered words plus reads that will
  // actually be kept. Issuing only below depth means a response can
  // always be written, so memory is never back-pressured.
  assign credits     = 32'(count_q) + 32'(infl_q) - 32'(drop_q);
  assign OUT_memReq  = rst && !IN_redirect && (32'(infl_q) < MAX_INFLIGHT)
                       && (credits < QUEUE_DEPTH);
  assign OUT_memAddr = fetch_pc_q;
  assign OUT_valid   = (count_q != '0);
  assign OUT_instr   = q_instr_q[head_q];
  assign OUT_pc      = q_pc_q[head_q];

  assign accept = OUT_memReq && !IN_memBusy;
  assign deq    = OUT_valid && IN_ready && !IN_redirect;
  assign enq    = IN_memValid && (drop_q == '0) && !IN_redirect;

  always_comb begin
    fetch_pc_d = accept ? fetch_pc_q + 32'd4 : fetch_pc_q;
    infl_d     = infl_q + IW'(accept) - IW'(IN_memValid);
    pf_wr_d    = accept ? pf_inc(pf_wr_q) : pf_wr_q;
    pf_rd_d    = IN_memValid ? pf_inc(pf_rd_q) : pf_rd_q;
    head_d     = deq ? head_q + QW'(1) : head_q;
    tail_d     = enq ? tail_q + QW'(1) : tail_q;
    count_d    = count_q + CW'(enq) - CW'(deq);
    drop_d     = (IN_memValid && drop_q != '0) ? drop_q - IW'(1) : drop_q;
    if (IN_redirect) begin
      fetch_pc_d = {IN_redirectPC[31:2], 2'b00};
      head_d     = '0;
      tail_d     = '0;
      count_d    = '0;
      // No issue this cycle, so infl_d is exactly the set of reads still
      // outstanding after the edge; all of them belong to the old path.
      drop_d     = infl_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc_q <= RESET_PC;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      infl_q     <= '0;
      drop_q     <= '0;
      pf_wr_q    <= '0;
      pf_rd_q    <= '0;
      for (int i = 0; i < QUEUE_DEPTH; i++) begin
        q_instr_q[i] <= '0;
        q_pc_q[i]    <= '0;
      end
      for (int i = 0; i < MAX_INFLIGHT; i++) pf_q[i] <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      infl_q     <= infl_d;
      drop_q     <= drop_d;
      pf_wr_q    <= pf_wr_d;
      pf_rd_q    <= pf_rd_d;
      if (enq) begin
        q_instr_q[tail_q] <= IN_memData;
        q_pc_q[tail_q]    <= pf_q[pf_rd_q];
      end
      if (accept) pf_q[pf_wr_q] <= fetch_pc_q;
    end
  end
endmodule
